// File: rtl/pe_echo_node.sv
// Mesh NoC endpoint: buffers flits addressed to this tile, increments each 32-bit
// payload lane and returns the flit to the scheduler tile with its packet number kept.
module pe_echo_node #(
   parameter int X_SIZE     = 2,
   parameter int Y_SIZE     = 2,
   parameter int PCK_NUM    = 5,
   parameter int DATA_WIDTH = 256,
   parameter int FIFO_DEPTH = 4,
   parameter int MY_X       = 0,
   parameter int MY_Y       = 1,
   parameter int RET_X      = 0,
   parameter int RET_Y      = 0
) (
   input  logic                                        clk,
   input  logic                                        rstn,
   input  logic                                        i_valid,
   input  logic [DATA_WIDTH+PCK_NUM+Y_SIZE+X_SIZE-1:0] i_data,
   output logic                                        o_ready,
   output logic                                        o_valid,
   output logic [DATA_WIDTH+PCK_NUM+Y_SIZE+X_SIZE-1:0] o_data,
   input  logic                                        i_ready,
   output logic [15:0]                                 o_pkt_cnt,
   output logic [15:0]                                 o_drop_cnt
);

   localparam int TW    = DATA_WIDTH + PCK_NUM + Y_SIZE + X_SIZE;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int PL    = X_SIZE + Y_SIZE + PCK_NUM;
   localparam int LANES = DATA_WIDTH / 32;

   logic [TW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   logic          addr_hit;
   logic          take;
   logic          push;
   logic          drop;
   logic          load;
   logic          xfer;
   logic [TW-1:0] head;
   logic [TW-1:0] next_flit;

   assign addr_hit = (i_data[X_SIZE-1:0] == X_SIZE'(MY_X)) &&
                     (i_data[X_SIZE +: Y_SIZE] == Y_SIZE'(MY_Y));
   assign o_ready  = (count != (AW+1)'(FIFO_DEPTH));
   assign take     = i_valid & o_ready;
   assign push     = take & addr_hit;
   assign drop     = take & ~addr_hit;
   assign xfer     = o_valid & i_ready;
   // No pop bypass: the output register only draws from an already-buffered flit.
   assign load     = (count != '0) & (~o_valid | i_ready);
   assign head     = mem[rd_ptr];

   always_comb begin
      next_flit = head;
      for (int unsigned k = 0; k < LANES; k++) begin
         next_flit[PL + 32*k +: 32] = head[PL + 32*k +: 32] + 32'd1;
      end
      next_flit[X_SIZE +: Y_SIZE] = Y_SIZE'(RET_Y);
      next_flit[X_SIZE-1:0]       = X_SIZE'(RET_X);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (load) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !load) begin
            count <= count + (AW+1)'(1);
         end else if (load && !push) begin
            count <= count - (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         o_valid    <= 1'b0;
         o_data     <= '0;
         o_pkt_cnt  <= '0;
         o_drop_cnt <= '0;
      end else begin
         if (load) begin
            o_valid <= 1'b1;
            o_data  <= next_flit;
         end else if (i_ready) begin
            o_valid <= 1'b0;
         end
         if (xfer) begin
            o_pkt_cnt <= o_pkt_cnt + 16'd1;
         end
         if (drop) begin
            o_drop_cnt <= o_drop_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_pe_echo_node.sv
// Self-checking bench for pe_echo_node: directed scenarios plus randomized traffic
// compared against a queue-based reference of the endpoint's behaviour.
module tb_pe_echo_node;

   localparam int XS    = 2;
   localparam int YS    = 2;
   localparam int PN    = 5;
   localparam int DW    = 256;
   localparam int DEPTH = 4;
   localparam int TW    = DW + PN + YS + XS;
   localparam int PL    = XS + YS + PN;

   logic          clk;
   logic          rstn;
   logic          i_valid;
   logic [TW-1:0] i_data;
   logic          o_ready;
   logic          o_valid;
   logic [TW-1:0] o_data;
   logic          i_ready;
   logic [15:0]   o_pkt_cnt;
   logic [15:0]   o_drop_cnt;

   int checks   = 0;
   int failures = 0;

   pe_echo_node #(
      .X_SIZE(XS), .Y_SIZE(YS), .PCK_NUM(PN), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
      .MY_X(0), .MY_Y(1), .RET_X(0), .RET_Y(0)
   ) dut (
      .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
      .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
      .o_pkt_cnt(o_pkt_cnt), .o_drop_cnt(o_drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state: flits waiting inside the endpoint, the presented return flit, counters.
   logic [TW-1:0] mq[$];
   logic          mv;
   logic [TW-1:0] md;
   logic [15:0]   mpkt;
   logic [15:0]   mdrop;

   function automatic logic [TW-1:0] mk(input int x, input int y, input int pck,
                                        input logic [DW-1:0] pay);
      logic [TW-1:0] f;
      f = {pay, PN'(pck), YS'(y), XS'(x)};
      return f;
   endfunction

   function automatic logic [TW-1:0] echo(input logic [TW-1:0] f);
      logic [TW-1:0] r;
      logic [31:0]   lane;
      r = f;
      for (int k = 0; k < DW/32; k++) begin
         lane = f[PL + 32*k +: 32];
         r[PL + 32*k +: 32] = lane + 32'd1;
      end
      r[XS +: YS] = '0;
      r[XS-1:0]   = '0;
      return r;
   endfunction

   function automatic logic [DW-1:0] rand_pay();
      logic [DW-1:0] p;
      for (int k = 0; k < DW/32; k++) p[32*k +: 32] = $urandom;
      return p;
   endfunction

   function automatic int pck_of(input logic [TW-1:0] f);
      return int'(f[XS+YS +: PN]);
   endfunction

   task automatic model_clear();
      mq.delete();
      mv    = 1'b0;
      md    = '0;
      mpkt  = '0;
      mdrop = '0;
   endtask

   // Drives one cycle from posedge+1, advances the reference, returns at the next posedge+1.
   task automatic drive_cycle(input logic v, input logic [TW-1:0] d, input logic r);
      bit acc;
      bit ld;
      i_valid = v;
      i_data  = d;
      i_ready = r;
      acc = v && (mq.size() != DEPTH);
      ld  = (mq.size() != 0) && (!mv || r);
      @(posedge clk);
      if (mv && r) mpkt = mpkt + 16'd1;
      if (ld) begin
         md = echo(mq.pop_front());
         mv = 1'b1;
      end else if (r) begin
         mv = 1'b0;
      end
      if (acc) begin
         if (d[XS-1:0] == 0 && d[XS +: YS] == 1) mq.push_back(d);
         else mdrop = mdrop + 16'd1;
      end
      #1;
   endtask

   task automatic apply_reset();
      i_valid = 1'b0;
      i_data  = '0;
      i_ready = 1'b0;
      rstn    = 1'b0;
      model_clear();
      @(posedge clk);
      #3 rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      i_valid = 1'b0;
      i_data  = '0;
      i_ready = 1'b0;
      rstn    = 1'b0;
      model_clear();
      #2;
      checks += 5;
      if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%0b exp=0", o_valid); end
      if (o_data !== '0) begin failures++; $display("FAIL reset_o_data got=%h exp=0", o_data); end
      if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_o_ready got=%0b exp=1", o_ready); end
      if (o_pkt_cnt !== 16'd0) begin failures++; $display("FAIL reset_pkt_cnt got=%0d exp=0", o_pkt_cnt); end
      if (o_drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", o_drop_cnt); end
      @(posedge clk);
      #3 rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      logic [DW-1:0] ones;
      logic [DW-1:0] twos;
      logic [TW-1:0] exp;
      apply_reset();
      for (int k = 0; k < DW/32; k++) begin
         ones[32*k +: 32] = 32'h0000_0001;
         twos[32*k +: 32] = 32'h0000_0002;
      end
      exp = mk(0, 0, 5, twos);
      drive_cycle(1'b1, mk(0, 1, 5, ones), 1'b1);
      checks++;
      if (o_valid !== 1'b0) begin failures++; $display("FAIL single_not_yet got=%0b exp=0", o_valid); end
      drive_cycle(1'b0, '0, 1'b1);
      checks += 2;
      if (o_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", o_valid); end
      if (o_data !== exp) begin failures++; $display("FAIL single_data got=%h exp=%h", o_data, exp); end
      drive_cycle(1'b0, '0, 1'b1);
      checks += 2;
      if (o_pkt_cnt !== 16'd1) begin failures++; $display("FAIL single_pkt_cnt got=%0d exp=1", o_pkt_cnt); end
      if (o_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%0b exp=0", o_valid); end
   endtask

   task automatic test_lane_wrap();
      logic [DW-1:0] pay;
      logic [TW-1:0] f;
      apply_reset();
      pay = rand_pay();
      pay[31:0]  = 32'hFFFF_FFFF;
      pay[63:32] = 32'h0000_0000;
      f = mk(0, 1, 17, pay);
      drive_cycle(1'b1, f, 1'b1);
      drive_cycle(1'b0, '0, 1'b1);
      checks += 3;
      if (o_data[PL +: 32] !== 32'h0) begin failures++; $display("FAIL wrap_lane0 got=%h exp=00000000", o_data[PL +: 32]); end
      if (o_data[PL+32 +: 32] !== 32'h1) begin failures++; $display("FAIL wrap_lane1 got=%h exp=00000001", o_data[PL+32 +: 32]); end
      if (o_data !== echo(f)) begin failures++; $display("FAIL wrap_flit got=%h exp=%h", o_data, echo(f)); end
   endtask

   task automatic test_misaddr();
      apply_reset();
      drive_cycle(1'b1, mk(1, 1, 3, rand_pay()), 1'b1);
      checks += 2;
      if (o_drop_cnt !== 16'd1) begin failures++; $display("FAIL misaddr_drop got=%0d exp=1", o_drop_cnt); end
      if (o_ready !== 1'b1) begin failures++; $display("FAIL misaddr_ready got=%0b exp=1", o_ready); end
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b0, '0, 1'b1);
         checks++;
         if (o_valid !== 1'b0) begin failures++; $display("FAIL misaddr_valid cyc=%0d got=%0b exp=0", i, o_valid); end
      end
   endtask

   task automatic test_backpressure();
      logic [TW-1:0] fl [6];
      int acc_cnt;
      int seen [$];
      bit sent5;
      apply_reset();
      for (int j = 0; j < 6; j++) fl[j] = mk(0, 1, j, rand_pay());
      acc_cnt = 0;
      for (int j = 0; j < 6; j++) begin
         if (j == 5) begin
            checks++;
            if (o_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%0b exp=0", o_ready); end
         end
         if (o_ready === 1'b1) acc_cnt++;
         drive_cycle(1'b1, fl[j], 1'b0);
      end
      checks += 2;
      if (acc_cnt !== 5) begin failures++; $display("FAIL bp_accepted got=%0d exp=5", acc_cnt); end
      if (o_valid !== 1'b1 || pck_of(o_data) !== 0) begin
         failures++; $display("FAIL bp_held got_valid=%0b got_pck=%0d exp_valid=1 exp_pck=0", o_valid, pck_of(o_data));
      end
      seen.push_back(pck_of(o_data));
      sent5 = 1'b0;
      for (int c = 0; c < 20 && seen.size() < 6; c++) begin
         bit pres;
         pres = !sent5;
         if (pres && o_ready === 1'b1) sent5 = 1'b1;
         drive_cycle(pres, fl[5], 1'b1);
         if (o_valid === 1'b1) seen.push_back(pck_of(o_data));
      end
      drive_cycle(1'b0, '0, 1'b1);
      checks += 3;
      if (seen.size() !== 6) begin failures++; $display("FAIL bp_outputs got=%0d exp=6", seen.size()); end
      for (int j = 0; j < seen.size() && j < 6; j++) begin
         checks++;
         if (seen[j] !== j) begin failures++; $display("FAIL bp_order idx=%0d got=%0d exp=%0d", j, seen[j], j); end
      end
      if (!sent5) begin failures++; $display("FAIL bp_flit5_accepted got=0 exp=1"); end
      if (o_pkt_cnt !== 16'd6) begin failures++; $display("FAIL bp_pkt_cnt got=%0d exp=6", o_pkt_cnt); end
   endtask

   task automatic test_streaming();
      apply_reset();
      for (int i = 0; i < 22; i++) begin
         checks++;
         if (o_ready !== 1'b1) begin failures++; $display("FAIL stream_ready cyc=%0d got=%0b exp=1", i, o_ready); end
         drive_cycle(i < 20, mk(0, 1, i % 32, rand_pay()), 1'b1);
         checks++;
         if (o_valid !== (i >= 1 && i <= 20)) begin
            failures++; $display("FAIL stream_valid cyc=%0d got=%0b exp=%0b", i, o_valid, (i >= 1 && i <= 20));
         end else if (o_valid) begin
            checks++;
            if (o_data !== md || pck_of(o_data) !== i - 1) begin
               failures++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", i, o_data, md);
            end
         end
      end
      checks++;
      if (o_pkt_cnt !== 16'd20) begin failures++; $display("FAIL stream_pkt_cnt got=%0d exp=20", o_pkt_cnt); end
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         logic [TW-1:0] f;
         int xy;
         xy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 4;
         f = mk(xy % 4, xy / 4, $urandom_range(0, 31), rand_pay());
         drive_cycle($urandom_range(0, 3) != 0, f, $urandom_range(0, 2) != 0);
         checks += 4;
         if (o_ready !== (mq.size() != DEPTH)) begin failures++; $display("FAIL rand_ready cyc=%0d got=%0b exp=%0b", c, o_ready, mq.size() != DEPTH); end
         if (o_valid !== mv) begin failures++; $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", c, o_valid, mv); end
         if (o_pkt_cnt !== mpkt) begin failures++; $display("FAIL rand_pkt_cnt cyc=%0d got=%0d exp=%0d", c, o_pkt_cnt, mpkt); end
         if (o_drop_cnt !== mdrop) begin failures++; $display("FAIL rand_drop_cnt cyc=%0d got=%0d exp=%0d", c, o_drop_cnt, mdrop); end
         if (mv) begin
            checks++;
            if (o_data !== md) begin failures++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, o_data, md); end
         end
      end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      drive_cycle(1'b1, mk(1, 0, 9, rand_pay()), 1'b0);
      for (int j = 0; j < 4; j++) drive_cycle(1'b1, mk(0, 1, j, rand_pay()), 1'b0);
      drive_cycle(1'b0, '0, 1'b0);
      checks += 2;
      if (o_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid got=%0b exp=1", o_valid); end
      if (o_drop_cnt !== 16'd1) begin failures++; $display("FAIL midrst_pre_drop got=%0d exp=1", o_drop_cnt); end
      #1 rstn = 1'b0;
      #1;
      checks += 4;
      if (o_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%0b exp=0", o_valid); end
      if (o_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%0b exp=1", o_ready); end
      if (o_pkt_cnt !== 16'd0) begin failures++; $display("FAIL midrst_pkt got=%0d exp=0", o_pkt_cnt); end
      if (o_drop_cnt !== 16'd0) begin failures++; $display("FAIL midrst_drop got=%0d exp=0", o_drop_cnt); end
      model_clear();
      #3 rstn = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) begin
         drive_cycle(1'b0, '0, 1'b1);
         checks++;
         if (o_valid !== 1'b0) begin failures++; $display("FAIL midrst_stale cyc=%0d got=%0b exp=0", i, o_valid); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_lane_wrap();
      test_misaddr();
      test_backpressure();
      test_streaming();
      test_random();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
